dso100_usb_phy_ctrl: RTL and testbench
======================================

DSO100_USB_PHY_CTRL -- requirements
Module: dso100_usb_phy_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 1000, is the PHY reset low time in clk cycles; legal range 1..2^20.
REQ-002 Parameter WAIT_CYCLES, default 10000, is the post-reset settle time before the PHY is ready; legal range 1..2^20.
REQ-003 Parameter DEBOUNCE_CYCLES, default 256, is the number of consecutive stable samples needed to change the fault level; legal range 1..2^16.
REQ-004 Parameter RETRY_CYCLES, default 1000000, is the fault cool-down time before an automatic retry; legal range 1..2^24.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 phy_reset_req  input  1  one-cycle request to restart the PHY reset sequence.
REQ-008 fault_clear  input  1  one-cycle request to leave FAULT.
REQ-009 otg_vbusoc  input  1  asynchronous VBUS overcurrent pin, active-low.
REQ-010 phy_resetn  output  1  drives the OTG PHY reset pad; low means the PHY is held in reset.
REQ-011 phy_ready  output  1  high only in state READY.
REQ-012 usb_pwrfault  output  1  debounced overcurrent indication to the PS, active-high.
REQ-013 busy  output  1  high in RST_ASSERT and RST_WAIT.
REQ-014 retry_cnt  output  4  saturating count of automatic retries.

Function
REQ-015 otg_vbusoc shall pass through a 2-flop synchronizer before any other use.
REQ-016 usb_pwrfault shall rise after DEBOUNCE_CYCLES consecutive synchronized-low samples and fall after DEBOUNCE_CYCLES consecutive synchronized-high samples; any opposite sample restarts the count.
REQ-017 Pin-to-usb_pwrfault latency shall be at least DEBOUNCE_CYCLES+2 cycles and at most DEBOUNCE_CYCLES+3 cycles.
REQ-018 The FSM shall have the states RST_ASSERT, RST_WAIT, READY and FAULT, with one shared down-counter of width clog2 of the largest parameter.
REQ-019 RST_ASSERT: phy_resetn=0; after RESET_CYCLES cycles, go to RST_WAIT.
REQ-020 RST_WAIT: phy_resetn=1; after WAIT_CYCLES cycles, go to READY.
REQ-021 READY: phy_resetn=1, phy_ready=1; phy_reset_req goes to RST_ASSERT.
REQ-022 phy_reset_req in RST_ASSERT or RST_WAIT shall reload the counter and (re)enter RST_ASSERT; phy_reset_req in FAULT shall be ignored.
REQ-023 usb_pwrfault=1 in any non-FAULT state shall go to FAULT on the next edge; in FAULT, phy_resetn=0.
REQ-024 FAULT exits to RST_ASSERT on fault_clear only while usb_pwrfault=0; fault_clear while usb_pwrfault=1 shall be ignored.
REQ-025 If usb_pwrfault and phy_reset_req are both 1 in the same cycle, FAULT shall win.
REQ-026 All outputs shall be registered, changing on the same edge as the state transition.

Reset
REQ-027 While rst=1: state=RST_ASSERT, counter loaded with RESET_CYCLES, phy_resetn=0, phy_ready=0, busy=1, usb_pwrfault=0, debounce count=0, synchronizer flops=1, retry_cnt=0.
REQ-028 rst asserted mid-sequence or in FAULT shall abort it; after rst falls, the reset sequence restarts, so phy_resetn stays low exactly RESET_CYCLES cycles from the first edge with rst=0.

Configuration
REQ-029 With DSO100_USB_AUTO_RETRY_EN defined: in FAULT with usb_pwrfault=0 held for RETRY_CYCLES consecutive cycles, go to RST_ASSERT and increment retry_cnt (saturate at 15); fault_clear still works; usb_pwrfault returning to 1 restarts the cool-down.
REQ-030 Without DSO100_USB_AUTO_RETRY_EN: only fault_clear exits FAULT, retry_cnt is constant 0, and no cool-down counter is synthesized.

Verification (RESET_CYCLES=10, WAIT_CYCLES=20, DEBOUNCE_CYCLES=4, RETRY_CYCLES=50)
REQ-031 Release rst at edge 0 -> phy_resetn low edges 0..9, high from edge 10; phy_ready=1 from edge 30; busy=0 from edge 30.
REQ-032 otg_vbusoc low for 3 cycles in READY -> usb_pwrfault stays 0, state stays READY; low for 8 cycles -> usb_pwrfault=1 within 6-7 cycles, phy_resetn=0, phy_ready=0.
REQ-033 In FAULT, fault_clear while the pin is low -> ignored; pin high 10 cycles, then fault_clear -> RST_ASSERT, phy_ready=1 30 cycles later.
REQ-034 phy_reset_req at cycle 15 of RST_WAIT -> phy_resetn low 10 cycles again, phy_ready 30 cycles after the request.
REQ-035 With the macro: fault, then pin high -> automatic RST_ASSERT 50 cycles after usb_pwrfault falls, retry_cnt=1; 20 repeated faults -> retry_cnt=15. Without the macro: FAULT persists for 1000 cycles and retry_cnt=0.
REQ-036 rst pulsed for 1 cycle during FAULT -> usb_pwrfault=0 and the reset sequence restarts per REQ-031 timing.

Source files
------------

// File: rtl/dso100_usb_phy_ctrl.sv
// dso100_usb_phy_ctrl: OTG PHY reset sequencer with debounced VBUS overcurrent fault.
// Optional automatic fault retry is enabled by defining DSO100_USB_AUTO_RETRY_EN.
module dso100_usb_phy_ctrl #(
    parameter int RESET_CYCLES    = 1000,
    parameter int WAIT_CYCLES     = 10000,
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int RETRY_CYCLES    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phy_reset_req,
    input  logic       fault_clear,
    input  logic       otg_vbusoc,
    output logic       phy_resetn,
    output logic       phy_ready,
    output logic       usb_pwrfault,
    output logic       busy,
    output logic [3:0] retry_cnt
);

    localparam int SEQ_MAX = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
`ifdef DSO100_USB_AUTO_RETRY_EN
    localparam int CNT_MAX = (RETRY_CYCLES > SEQ_MAX) ? RETRY_CYCLES : SEQ_MAX;
`else
    localparam int CNT_MAX = SEQ_MAX;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    // Reset loads the full count because the rst cycle itself is not counted;
    // in-band entries load one less because the entry edge is the first low cycle.
    localparam logic [CW-1:0] RST_FULL = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] RST_LOAD = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RST_ASSERT,
        RST_WAIT,
        READY,
        FAULT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] db_cnt_q;
    logic          pwrfault_q;
    logic          resetn_q;
    logic          ready_q;
    logic          busy_q;

    // Two-flop synchronizer for the async overcurrent pin; idles high (no fault).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= otg_vbusoc;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: flip the fault level after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q   <= '0;
            pwrfault_q <= 1'b0;
        end else if (db_cnt_q == DB_MAX) begin
            db_cnt_q   <= '0;
            pwrfault_q <= ~pwrfault_q;
        end else if (sync2_q == pwrfault_q) begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end else begin
            db_cnt_q <= '0;
        end
    end

`ifdef DSO100_USB_AUTO_RETRY_EN
    localparam logic [CW-1:0] RETRY_LOAD = CW'(RETRY_CYCLES - 1);
    logic [3:0] retry_q;
`endif

    // Sequencer FSM with registered outputs set alongside each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_ASSERT;
            cnt_q    <= RST_FULL;
            resetn_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef DSO100_USB_AUTO_RETRY_EN
            retry_q  <= 4'd0;
`endif
        end else if (pwrfault_q && state_q != FAULT) begin
            state_q  <= FAULT;
            resetn_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DSO100_USB_AUTO_RETRY_EN
            cnt_q    <= RETRY_LOAD;
`endif
        end else begin
            unique case (state_q)
                RST_ASSERT: begin
                    if (phy_reset_req) begin
                        cnt_q <= RST_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q  <= RST_WAIT;
                        cnt_q    <= WAIT_LOAD;
                        resetn_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (phy_reset_req) begin
                        state_q  <= RST_ASSERT;
                        cnt_q    <= RST_LOAD;
                        resetn_q <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                READY: begin
                    if (phy_reset_req) begin
                        state_q  <= RST_ASSERT;
                        cnt_q    <= RST_LOAD;
                        resetn_q <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                FAULT: begin
                    if (fault_clear && !pwrfault_q) begin
                        state_q <= RST_ASSERT;
                        cnt_q   <= RST_LOAD;
                        busy_q  <= 1'b1;
                    end
`ifdef DSO100_USB_AUTO_RETRY_EN
                    else if (pwrfault_q) begin
                        cnt_q <= RETRY_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q <= RST_ASSERT;
                        cnt_q   <= RST_LOAD;
                        busy_q  <= 1'b1;
                        if (retry_q != 4'hF) begin
                            retry_q <= retry_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign phy_resetn   = resetn_q;
    assign phy_ready    = ready_q;
    assign usb_pwrfault = pwrfault_q;
    assign busy         = busy_q;
`ifdef DSO100_USB_AUTO_RETRY_EN
    assign retry_cnt    = retry_q;
`else
    assign retry_cnt    = 4'd0;
`endif

endmodule

// File: tb/tb_dso100_usb_phy_ctrl.sv
// tb_dso100_usb_phy_ctrl: directed self-checking bench for dso100_usb_phy_ctrl.
// Builds with or without DSO100_USB_AUTO_RETRY_EN.
module tb_dso100_usb_phy_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       phy_reset_req;
    logic       fault_clear;
    logic       otg_vbusoc;
    logic       phy_resetn;
    logic       phy_ready;
    logic       usb_pwrfault;
    logic       busy;
    logic [3:0] retry_cnt;

    int checks = 0;
    int fails  = 0;

    dso100_usb_phy_ctrl #(
        .RESET_CYCLES   (10),
        .WAIT_CYCLES    (20),
        .DEBOUNCE_CYCLES(4),
        .RETRY_CYCLES   (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .phy_reset_req(phy_reset_req),
        .fault_clear  (fault_clear),
        .otg_vbusoc   (otg_vbusoc),
        .phy_resetn   (phy_resetn),
        .phy_ready    (phy_ready),
        .usb_pwrfault (usb_pwrfault),
        .busy         (busy),
        .retry_cnt    (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the reset sequence; e counts edges from the sequence origin.
    task automatic seq_chk(input int start);
        for (int e = start; e <= 31; e++) begin
            tick();
            chk($sformatf("seq_resetn_e%0d", e), phy_resetn, (e >= 10) ? 1 : 0);
            chk($sformatf("seq_ready_e%0d", e), phy_ready, (e >= 30) ? 1 : 0);
            chk($sformatf("seq_busy_e%0d", e), busy, (e < 30) ? 1 : 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        phy_reset_req = 1'b0;
        fault_clear   = 1'b0;
        otg_vbusoc    = 1'b1;
        repeat (3) tick();
        chk("rst_resetn", phy_resetn, 0);
        chk("rst_ready", phy_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_pwrfault", usb_pwrfault, 0);
        chk("rst_retry", retry_cnt, 0);

        rst = 1'b0;
        seq_chk(0);

        // 3-cycle glitch is filtered
        otg_vbusoc = 1'b0;
        repeat (3) tick();
        otg_vbusoc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch_pf", usb_pwrfault, 0);
            chk("glitch_ready", phy_ready, 1);
        end

        // sustained overcurrent
        otg_vbusoc = 1'b0;
        repeat (6) tick();
        chk("pf_early", usb_pwrfault, 0);
        tick();
        chk("pf_rise", usb_pwrfault, 1);
        chk("pf_ready_hold", phy_ready, 1);
        tick();
        chk("fault_resetn", phy_resetn, 0);
        chk("fault_ready", phy_ready, 0);
        chk("fault_busy", busy, 0);

        // clear ignored while fault active, request ignored in FAULT
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        tick();
        chk("clr_ignored_busy", busy, 0);
        chk("clr_ignored_resetn", phy_resetn, 0);
        phy_reset_req = 1'b1;
        tick();
        phy_reset_req = 1'b0;
        tick();
        chk("req_in_fault", busy, 0);

        // pin recovers, then clear
        otg_vbusoc = 1'b1;
        repeat (6) tick();
        chk("pf_hold", usb_pwrfault, 1);
        tick();
        chk("pf_fall", usb_pwrfault, 0);
        repeat (3) tick();
        chk("still_fault", busy, 0);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_resetn", phy_resetn, 0);
        seq_chk(1);

        // request from READY, then again at cycle 15 of RST_WAIT
        phy_reset_req = 1'b1;
        tick();
        phy_reset_req = 1'b0;
        chk("req_busy", busy, 1);
        chk("req_resetn", phy_resetn, 0);
        repeat (10) tick();
        chk("req_wait_resetn", phy_resetn, 1);
        repeat (14) tick();
        chk("req_wait_ready", phy_ready, 0);
        phy_reset_req = 1'b1;
        tick();
        phy_reset_req = 1'b0;
        chk("rereq_resetn", phy_resetn, 0);
        chk("rereq_busy", busy, 1);
        seq_chk(1);

        // fault beats request in the same cycle
        otg_vbusoc = 1'b0;
        repeat (7) tick();
        chk("fw_pf", usb_pwrfault, 1);
        phy_reset_req = 1'b1;
        tick();
        phy_reset_req = 1'b0;
        chk("fault_wins_busy", busy, 0);
        chk("fault_wins_resetn", phy_resetn, 0);

        // rst pulse during FAULT
        otg_vbusoc = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstf_pf", usb_pwrfault, 0);
        chk("rstf_busy", busy, 1);
        chk("rstf_resetn", phy_resetn, 0);
        chk("rstf_ready", phy_ready, 0);
        seq_chk(0);

        // cool-down behaviour
        otg_vbusoc = 1'b0;
        repeat (8) tick();
        chk("cd_fault", busy, 0);
        otg_vbusoc = 1'b1;
        repeat (7) tick();
        chk("cd_pf_fall", usb_pwrfault, 0);
`ifdef DSO100_USB_AUTO_RETRY_EN
        repeat (49) tick();
        chk("cd_wait", busy, 0);
        tick();
        chk("auto_retry_busy", busy, 1);
        chk("auto_retry_cnt", retry_cnt, 1);
        for (int i = 0; i < 19; i++) begin
            otg_vbusoc = 1'b0;
            repeat (8) tick();
            otg_vbusoc = 1'b1;
            repeat (57) tick();
        end
        chk("retry_sat", retry_cnt, 15);
        chk("retry_sat_busy", busy, 1);
`else
        repeat (1000) tick();
        chk("no_retry_busy", busy, 0);
        chk("no_retry_resetn", phy_resetn, 0);
        chk("no_retry_ready", phy_ready, 0);
        chk("no_retry_cnt", retry_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
